// File: rtl/alu_mem_datapath.sv
// Execute-stage datapath: ALU control decode, 64-bit ALU with flags, and a
// byte-addressed little-endian data memory addressed by the ALU result.
module alu_mem_datapath #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUOp,
  input  logic [3:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] write_data,
  output logic [3:0]        ALUCtrl,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow,
  output logic [DATA_W-1:0] read_data
);

  localparam int NB     = DATA_W / 8;
  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int SH_W   = $clog2(DATA_W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SH_W-1:0]   shamt;
  logic              mem_ok;
  logic [ADDR_W-1:0] base;
  logic [7:0]        mem_q [MEM_BYTES];
  logic [7:0]        mem_d [MEM_BYTES];

  always_comb begin
    ALUCtrl = OP_ADD;
    case (ALUOp)
      2'b01: ALUCtrl = OP_SUB;
      2'b10: begin
        case (funct)
          4'b0000: ALUCtrl = OP_ADD;
          4'b1000: ALUCtrl = OP_SUB;
          4'b0001: ALUCtrl = OP_SLL;
          4'b0010: ALUCtrl = OP_SLT;
          4'b0011: ALUCtrl = OP_SLTU;
          4'b0100: ALUCtrl = OP_XOR;
          4'b0101: ALUCtrl = OP_SRL;
          4'b1101: ALUCtrl = OP_SRA;
          4'b0110: ALUCtrl = OP_OR;
          4'b0111: ALUCtrl = OP_AND;
          default: ALUCtrl = OP_ADD;
        endcase
      end
      default: ALUCtrl = OP_ADD;
    endcase
  end

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (ALUCtrl)
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_XOR:  alu_result = a ^ b;
      OP_ADD: begin
        alu_result = sum;
        overflow   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_result = diff;
        overflow   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLL:  alu_result = a << shamt;
      OP_SRL:  alu_result = a >> shamt;
      OP_SRA:  alu_result = $signed(a) >>> shamt;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, a < b};
      default: alu_result = '0;
    endcase
  end

  assign zero = ~|alu_result;

  // Compare without adding 7 so addresses near 2^64 cannot wrap into range.
  assign mem_ok = alu_result <= DATA_W'(MEM_BYTES - NB);
  assign base   = alu_result[ADDR_W-1:0];

  always_comb begin
    read_data = '0;
    if (rst_n && MemRead && mem_ok) begin
      for (int k = 0; k < NB; k++) begin
        read_data[8*k +: 8] = mem_q[base + ADDR_W'(k)];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (MemWrite && mem_ok) begin
      for (int k = 0; k < NB; k++) begin
        mem_d[base + ADDR_W'(k)] = write_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Randomized bench for alu_mem_datapath against an arithmetic reference model
// with a byte-array memory image.
module tb_alu_mem_datapath;

  localparam int DW  = 64;
  localparam int MEM = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ALUOp;
  logic [3:0]    funct;
  logic [DW-1:0] a, b, write_data;
  logic          MemRead, MemWrite;
  logic [3:0]    ALUCtrl;
  logic [DW-1:0] alu_result, read_data;
  logic          zero, overflow;

  alu_mem_datapath #(.DATA_W(DW), .MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .funct(funct), .a(a), .b(b),
    .MemRead(MemRead), .MemWrite(MemWrite), .write_data(write_data),
    .ALUCtrl(ALUCtrl), .alu_result(alu_result), .zero(zero),
    .overflow(overflow), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [MEM];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model_alu(input logic [1:0] op, input logic [3:0] fn,
                                    input logic [63:0] x, input logic [63:0] y,
                                    output logic [3:0] ctl, output logic [63:0] r,
                                    output logic ov);
    logic signed [64:0] wide;
    if (op == 2'b01) ctl = 4'b0110;
    else if (op == 2'b10) begin
      case (fn)
        4'b0000: ctl = 4'b0010;
        4'b1000: ctl = 4'b0110;
        4'b0001: ctl = 4'b0100;
        4'b0010: ctl = 4'b1000;
        4'b0011: ctl = 4'b1001;
        4'b0100: ctl = 4'b0011;
        4'b0101: ctl = 4'b0101;
        4'b1101: ctl = 4'b0111;
        4'b0110: ctl = 4'b0001;
        4'b0111: ctl = 4'b0000;
        default: ctl = 4'b0010;
      endcase
    end else ctl = 4'b0010;
    r  = '0;
    ov = 1'b0;
    case (ctl)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b0010: begin
        wide = $signed({x[63], x}) + $signed({y[63], y});
        r    = wide[63:0];
        ov   = wide[64] ^ wide[63];
      end
      4'b0110: begin
        wide = $signed({x[63], x}) - $signed({y[63], y});
        r    = wide[63:0];
        ov   = wide[64] ^ wide[63];
      end
      4'b0100: r = x << y[5:0];
      4'b0101: r = x >> y[5:0];
      4'b0111: r = 64'($signed(x) >>> y[5:0]);
      4'b1000: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'b1001: r = (x < y) ? 64'd1 : 64'd0;
      default: r = '0;
    endcase
  endfunction

  function automatic logic in_range(input logic [63:0] addr);
    return ({1'b0, addr} + 65'd7) < 65'(MEM);
  endfunction

  function automatic logic [63:0] model_addr();
    logic [3:0] c; logic [63:0] r; logic o;
    model_alu(ALUOp, funct, a, b, c, r, o);
    return r;
  endfunction

  function automatic logic [63:0] model_read();
    logic [63:0] addr, v;
    addr = model_addr();
    v = '0;
    if (rst_n && MemRead && in_range(addr))
      for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_mem[int'(addr) + k];
    return v;
  endfunction

  task automatic check_alu(input string tag);
    logic [3:0] c; logic [63:0] r; logic o;
    model_alu(ALUOp, funct, a, b, c, r, o);
    check_val({tag, ".ctrl"}, 64'(ALUCtrl), 64'(c));
    check_val({tag, ".res"}, alu_result, r);
    check_val({tag, ".zero"}, 64'(zero), 64'(r == 64'd0));
    check_val({tag, ".ovf"}, 64'(overflow), 64'(o));
  endtask

  task automatic check_rd(input string tag);
    check_val(tag, read_data, model_read());
  endtask

  task automatic step();
    logic [63:0] addr;
    addr = model_addr();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
    end else if (MemWrite && in_range(addr)) begin
      for (int k = 0; k < 8; k++) ref_mem[int'(addr) + k] = write_data[8*k +: 8];
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [63:0] x,
                       input logic [63:0] y, input logic mr, input logic mw,
                       input logic [63:0] wd);
    ALUOp = op; funct = fn; a = x; b = y;
    MemRead = mr; MemWrite = mw; write_data = wd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    drive(2'b00, 4'h0, 64'd24, 64'd0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001);
    step();
    check_val("rst.rd_held", read_data, 64'd0);
    check_val("rst.alu_live", alu_result, 64'd24);
    rst_n = 1'b1;
    drive(2'b00, 4'h0, 64'd24, 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("rst.mem_clear", read_data, 64'd0);

    drive(2'b10, 4'b1000, 64'd5, 64'd7, 1'b0, 1'b0, 64'd0);
    check_val("sub.ctrl", 64'(ALUCtrl), 64'h6);
    check_val("sub.res", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("sub.zero", 64'(zero), 64'd0);
    check_val("sub.ovf", 64'(overflow), 64'd0);
    drive(2'b00, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0);
    check_val("addovf.res", alu_result, 64'h8000_0000_0000_0000);
    check_val("addovf.ovf", 64'(overflow), 64'd1);
    drive(2'b01, 4'hF, 64'h1234, 64'h1234, 1'b0, 1'b0, 64'd0);
    check_val("beq.res", alu_result, 64'd0);
    check_val("beq.zero", 64'(zero), 64'd1);
    drive(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 1'b0, 64'd0);
    check_val("sra.res", alu_result, 64'hF800_0000_0000_0000);
    drive(2'b10, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0);
    check_val("sltu.res", alu_result, 64'd0);

    drive(2'b00, 4'h0, 64'd16, 64'd8, 1'b0, 1'b1, 64'h1122_3344_5566_7788);
    step();
    drive(2'b00, 4'h0, 64'd16, 64'd8, 1'b1, 1'b0, 64'd0);
    check_val("st.rd", read_data, 64'h1122_3344_5566_7788);
    check_val("st.byte24", 64'(read_data[7:0]), 64'h88);
    drive(2'b00, 4'h0, 64'd25, 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("st.misalign", read_data, 64'h0011_2233_4455_6677);

    rst_n = 1'b0;
    drive(2'b00, 4'h0, 64'd24, 64'd0, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    rst_n = 1'b1;
    drive(2'b00, 4'h0, 64'd24, 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("rst2.rd24", read_data, 64'd0);
    drive(2'b00, 4'h0, 64'(MEM - 4), 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(2'b00, 4'h0, 64'(MEM - 4), 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("oob.rd", read_data, 64'd0);
    drive(2'b00, 4'h0, 64'(MEM - 8), 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("oob.no_spill", read_data, 64'd0);
    drive(2'b00, 4'h0, 64'(MEM - 8), 64'd0, 1'b0, 1'b1, 64'h0102_0304_0506_0708);
    step();
    drive(2'b00, 4'h0, 64'(MEM - 8), 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("top.rd", read_data, 64'h0102_0304_0506_0708);

    for (int i = 0; i < 300; i++) begin
      logic [63:0] x, y;
      x = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: y = 64'($urandom_range(0, 70));
        1: y = x;
        2: y = {x[63], 63'($urandom)};
        default: y = {$urandom, $urandom};
      endcase
      drive(2'($urandom), 4'($urandom), x, y, 1'b0, 1'b0, 64'd0);
      check_alu($sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 200; i++) begin
      logic [63:0] addr;
      addr = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 48))
                                         : 64'($urandom_range(MEM - 16, MEM + 4));
      drive(2'b11, 4'($urandom), addr - 64'd3, 64'd3, 1'($urandom), 1'($urandom),
            {$urandom, $urandom});
      check_rd($sformatf("mem%0d.pre", i));
      step();
      check_rd($sformatf("mem%0d.post", i));
    end

    rst_n = 1'b0;
    drive(2'b00, 4'h0, 64'd100, 64'd0, 1'b1, 1'b1, 64'h5555_6666_7777_8888);
    check_val("midst.rd_rst", read_data, 64'd0);
    step();
    rst_n = 1'b1;
    drive(2'b00, 4'h0, 64'd100, 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("midst.rd", read_data, 64'd0);
    drive(2'b00, 4'h0, 64'd8, 64'd0, 1'b1, 1'b0, 64'd0);
    check_val("midst.rd8", read_data, 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
